// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: state encoding, default burst cap and a clog2 helper shared by
// the round-robin mux arbiter and its bench.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_BURST_DEFAULT = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority selector; the first set request
// at or after start (wrapping modulo NREQ) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            c;
    logic [IW-1:0] ci;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        ci     = '0;
        // Walk offsets from farthest to nearest so the nearest set request is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(start) + k;
            if (c >= NREQ) c = c - NREQ;
            ci = IW'(c);
            if (req[ci]) begin
                idx = ci;
                any = 1'b1;
            end
        end
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner of an NREQ:1 mux feeding a registered VALID/READY output.
// Define BURST_LIMIT_EN to force rotation after MAX_BURST consecutive captures by one owner.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SIZE      = 1,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*SIZE-1:0]   DIN,
    input  logic                   READY,
    output logic [NREQ-1:0]        TAKE,
    output logic [NREQ-1:0]        GNT,
    output logic [clog2(NREQ)-1:0] SEL,
    output logic [SIZE-1:0]        OUT,
    output logic                   VALID
);

    localparam int IW = clog2(NREQ);

    state_t          state, state_nx;
    logic [IW-1:0]   last_owner, start_idx, pick_idx, win_idx;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any, keep, has_win, free, capture;
    logic [SIZE-1:0] mux_word;

`ifdef BURST_LIMIT_EN
    localparam int BW = clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt;
    assign keep = (state == GRANT) && REQ[SEL] && (burst_cnt < BW'(MAX_BURST));
`else
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST > 0);
    assign keep = (state == GRANT) && REQ[SEL];
`endif

    // In GRANT last_owner equals SEL, so one picker serves both the idle scan and rotation.
    assign start_idx = (last_owner == IW'(NREQ - 1)) ? '0 : last_owner + IW'(1);

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (REQ),
        .start  (start_idx),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign win_idx = keep ? SEL : pick_idx;
    assign has_win = (state != DRAIN) && (keep || pick_any);
    assign free    = !VALID || READY;
    assign capture = !RST && has_win && free;

    always_comb begin
        mux_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) mux_word = DIN[i*SIZE +: SIZE];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            GNT        <= '0;
            SEL        <= '0;
            OUT        <= '0;
            VALID      <= 1'b0;
            last_owner <= IW'(NREQ - 1);
        end else begin
            state <= state_nx;
            if (capture) begin
                OUT        <= mux_word;
                VALID      <= 1'b1;
                GNT        <= TAKE;
                SEL        <= win_idx;
                last_owner <= win_idx;
            end else if (state_nx == IDLE) begin
                VALID <= 1'b0;
                GNT   <= '0;
            end
        end
    end

`ifdef BURST_LIMIT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burst_cnt <= '0;
        end else if (capture) begin
            // A lone owner re-selected past the cap saturates so any newcomer wins at once.
            if ((state == GRANT) && (win_idx == SEL))
                burst_cnt <= (burst_cnt < BW'(MAX_BURST)) ? burst_cnt + BW'(1) : burst_cnt;
            else
                burst_cnt <= BW'(1);
        end else if (state_nx == IDLE) begin
            burst_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (capture) state_nx = GRANT;
            GRANT:   if (!has_win) state_nx = (VALID && !READY) ? DRAIN : IDLE;
            DRAIN:   if (READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        TAKE = '0;
        if (capture) TAKE = keep ? GNT : pick_oh;
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed tables, hand sequences and a random run against
// an integer-level round-robin reference model.
module tb_rr_mux_arbiter;
    import mux_arb_pkg::*;

    localparam int SIZE      = 6;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
`ifdef BURST_LIMIT_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      REQ;
    logic [NREQ*SIZE-1:0] DIN;
    logic                 READY;
    logic [NREQ-1:0]      TAKE, GNT;
    logic [1:0]           SEL;
    logic [SIZE-1:0]      OUT;
    logic                 VALID;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .DIN   (DIN),
        .READY (READY),
        .TAKE  (TAKE),
        .GNT   (GNT),
        .SEL   (SEL),
        .OUT   (OUT),
        .VALID (VALID)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*SIZE-1:0] d, input logic rd);
        @(negedge CLK);
        REQ   = r;
        DIN   = d;
        READY = rd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        REQ   = '0;
        READY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Reference model: owner/last as plain integers, -1 meaning no owner.
    int              m_owner, m_last, m_sel, m_burst;
    bit              m_valid, m_drain;
    logic [SIZE-1:0] m_out;

    task automatic model_reset();
        m_owner = -1;
        m_last  = NREQ - 1;
        m_sel   = 0;
        m_burst = 0;
        m_valid = 1'b0;
        m_drain = 1'b0;
        m_out   = '0;
    endtask

    function automatic int model_winner();
        if (m_drain) return -1;
        if (m_owner >= 0 && REQ[m_owner] && (!BURST_ON || m_burst < MAX_BURST)) return m_owner;
        for (int k = 1; k <= NREQ; k++) begin
            if (REQ[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step(output logic [NREQ-1:0] exp_take);
        int                   w;
        bit                   fr;
        logic [NREQ*SIZE-1:0] d;
        w        = model_winner();
        fr       = !m_valid || READY;
        d        = DIN;
        exp_take = '0;
        if (w >= 0 && fr) begin
            exp_take[w] = 1'b1;
            m_burst = (w == m_owner) ? ((m_burst < MAX_BURST) ? m_burst + 1 : m_burst) : 1;
            m_out   = d[w*SIZE +: SIZE];
            m_valid = 1'b1;
            m_owner = w;
            m_last  = w;
            m_sel   = w;
        end else if (w < 0) begin
            if (m_valid && !READY) begin
                m_drain = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_owner = -1;
                m_drain = 1'b0;
                m_burst = 0;
            end
        end
    endtask

    task automatic model_cycle();
        logic [NREQ-1:0] et;
        model_step(et);
        #1;
        check("rnd take", TAKE, et);
        tick();
        check("rnd gnt", GNT, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("rnd sel", SEL, m_sel);
        check("rnd out", OUT, m_out);
        check("rnd valid", VALID, m_valid);
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic            ready;
        logic [NREQ-1:0] take;
        logic [NREQ-1:0] gnt;
        logic [SIZE-1:0] out;
        logic            valid;
    } vec_t;

    vec_t                 vecs[7];
    logic [NREQ*SIZE-1:0] fair_din;
    logic [NREQ*SIZE-1:0] d;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fair_din = {6'h3D, 6'h2C, 6'h1B, 6'h0A};
        vecs[0] = '{4'b1111, 1'b1, 4'b0001, 4'b0001, 6'h0A, 1'b1};
        vecs[1] = '{4'b1110, 1'b1, 4'b0010, 4'b0010, 6'h1B, 1'b1};
        vecs[2] = '{4'b1100, 1'b1, 4'b0100, 4'b0100, 6'h2C, 1'b1};
        vecs[3] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 6'h3D, 1'b1};
        vecs[4] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 6'h3D, 1'b0};
        vecs[5] = '{4'b0010, 1'b0, 4'b0010, 4'b0010, 6'h1B, 1'b1};
        vecs[6] = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 6'h1B, 1'b1};

        // Reset held with all requests high
        RST   = 1'b1;
        REQ   = '1;
        DIN   = fair_din;
        READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst gnt", GNT, 0);
        check("rst valid", VALID, 0);
        check("rst out", OUT, 0);
        check("rst sel", SEL, 0);
        check("rst take", TAKE, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst first take", TAKE, 4'b0001);
        tick();
        check("rst first out", OUT, 6'h0A);
        check("rst first gnt", GNT, 4'b0001);

        // Round-robin fairness table
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].req, fair_din, vecs[i].ready);
            #1;
            check("tbl take", TAKE, vecs[i].take);
            tick();
            check("tbl gnt", GNT, vecs[i].gnt);
            check("tbl out", OUT, vecs[i].out);
            check("tbl valid", VALID, vecs[i].valid);
        end

        // Backpressure: word held, then consumed with a same-edge capture
        do_reset();
        d = {6'h00, 6'h15, 6'h00, 6'h00};
        drive(4'b0100, d, 1'b0);
        #1;
        check("bp take", TAKE, 4'b0100);
        tick();
        check("bp out", OUT, 6'h15);
        d = {6'h00, 6'h2A, 6'h00, 6'h00};
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, d, 1'b0);
            #1;
            check("bp stall take", TAKE, 0);
            tick();
            check("bp stall out", OUT, 6'h15);
            check("bp stall valid", VALID, 1);
            check("bp stall gnt", GNT, 4'b0100);
        end
        drive(4'b0100, d, 1'b1);
        #1;
        check("bp release take", TAKE, 4'b0100);
        tick();
        check("bp release out", OUT, 6'h2A);
        check("bp release valid", VALID, 1);

        // Drain: owner leaves while the consumer stalls
        do_reset();
        d = {6'h00, 6'h00, 6'h00, 6'h07};
        drive(4'b0001, d, 1'b0);
        tick();
        check("dr out", OUT, 6'h07);
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, d, 1'b0);
            #1;
            check("dr take", TAKE, 0);
            tick();
            check("dr state", dut.state, DRAIN);
            check("dr gnt", GNT, 4'b0001);
            check("dr valid", VALID, 1);
        end
        drive(4'b0000, d, 1'b1);
        tick();
        check("dr end state", dut.state, IDLE);
        check("dr end gnt", GNT, 0);
        check("dr end valid", VALID, 0);

        // Asynchronous reset in the middle of a burst
        do_reset();
        drive(4'b0110, fair_din, 1'b1);
        tick();
        drive(4'b0110, fair_din, 1'b1);
        tick();
        @(posedge CLK);
        #2;
        check("ar pre valid", VALID, 1);
        RST = 1'b1;
        #1;
        check("ar valid", VALID, 0);
        check("ar gnt", GNT, 0);
        check("ar out", OUT, 0);
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'b1111;
        #1;
        check("ar next take", TAKE, 4'b0001);
        tick();
        check("ar next gnt", GNT, 4'b0001);

        // Burst cap: two requesters held high
        do_reset();
        d = {6'h00, 6'h00, 6'h11, 6'h01};
        for (int i = 0; i < 8; i++) begin
            drive(4'b0011, d, 1'b1);
            tick();
            check("burst gnt", GNT, (BURST_ON && i >= 4) ? 4'b0010 : 4'b0001);
            check("burst valid", VALID, 1);
        end

        // Random traffic against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            drive(NREQ'($urandom), (NREQ*SIZE)'($urandom), ($urandom_range(0, 9) < 7));
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
